// File: rtl/mag_timer.sv
// rtl/mag_timer.sv - BCD MM:SS countdown timer feeding the magnetron timer_done input
module mag_timer #(
  parameter int TICKS_PER_SEC = 1000,
  parameter int PRESC_W       = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clearn,
  input  logic       load_digit,
  input  logic [3:0] digit,
  input  logic       mag_on,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       sec_tick,
  output logic       timer_done
);

  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICKS_PER_SEC - 1);

  logic [PRESC_W-1:0] presc;
  logic [3:0]         dec_mt, dec_mo, dec_st, dec_so;
  logic               is_zero;
  logic               entry_ok;
  logic               counting;

  assign is_zero    = (min_tens == 4'd0) && (min_ones == 4'd0) &&
                      (sec_tens == 4'd0) && (sec_ones == 4'd0);
  assign timer_done = is_zero;
  assign entry_ok   = load_digit && !mag_on && (digit <= 4'd9);
  assign counting   = mag_on && !is_zero;

  // One-second BCD decrement; sec_tens borrows to 5 but entered 6..9 count down normally.
  always_comb begin
    dec_mt = min_tens;
    dec_mo = min_ones;
    dec_st = sec_tens;
    dec_so = sec_ones;
    if (sec_ones != 4'd0) begin
      dec_so = sec_ones - 4'd1;
    end else begin
      dec_so = 4'd9;
      if (sec_tens != 4'd0) begin
        dec_st = sec_tens - 4'd1;
      end else begin
        dec_st = 4'd5;
        if (min_ones != 4'd0) begin
          dec_mo = min_ones - 4'd1;
        end else begin
          dec_mo = 4'd9;
          dec_mt = min_tens - 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    sec_tick <= 1'b0;
    if (rst || !clearn) begin
      min_tens <= 4'd0;
      min_ones <= 4'd0;
      sec_tens <= 4'd0;
      sec_ones <= 4'd0;
      presc    <= '0;
    end else if (entry_ok) begin
      min_tens <= min_ones;
      min_ones <= sec_tens;
      sec_tens <= sec_ones;
      sec_ones <= digit;
      presc    <= '0;
    end else if (counting) begin
      if (presc == PRESC_MAX) begin
        presc    <= '0;
        min_tens <= dec_mt;
        min_ones <= dec_mo;
        sec_tens <= dec_st;
        sec_ones <= dec_so;
        sec_tick <= 1'b1;
      end else begin
        presc <= presc + 1'b1;
      end
    end else if (mag_on) begin
      // Zero time: keep the prescaler parked so a later load starts a full second.
      presc <= '0;
    end
  end

endmodule

// File: tb/tb_mag_timer.sv
// tb/tb_mag_timer.sv - directed bench for mag_timer with TICKS_PER_SEC=4
module tb_mag_timer;

  logic       clk;
  logic       rst;
  logic       clearn;
  logic       load_digit;
  logic [3:0] digit;
  logic       mag_on;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic       sec_tick;
  logic       timer_done;

  int pass_cnt;
  int total_cnt;

  mag_timer #(.TICKS_PER_SEC(4), .PRESC_W(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .clearn     (clearn),
    .load_digit (load_digit),
    .digit      (digit),
    .mag_on     (mag_on),
    .min_tens   (min_tens),
    .min_ones   (min_ones),
    .sec_tens   (sec_tens),
    .sec_ones   (sec_ones),
    .sec_tick   (sec_tick),
    .timer_done (timer_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] cur_time();
    return {min_tens, min_ones, sec_tens, sec_ones};
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input logic [3:0] d);
    load_digit = 1'b1;
    digit      = d;
    @(negedge clk);
    load_digit = 1'b0;
    digit      = 4'd0;
  endtask

  task automatic load4(input logic [15:0] t);
    load(t[15:12]);
    load(t[11:8]);
    load(t[7:4]);
    load(t[3:0]);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    total_cnt++;
    if (cur_time() !== 16'h0000) $display("FAIL reset_time got %h want 0000", cur_time());
    else pass_cnt++;
    total_cnt++;
    if (timer_done !== 1'b1) $display("FAIL reset_done got %b want 1", timer_done);
    else pass_cnt++;
    total_cnt++;
    if (sec_tick !== 1'b0) $display("FAIL reset_tick got %b want 0", sec_tick);
    else pass_cnt++;
  endtask

  task automatic test_entry();
    load(4'd1); load(4'd2); load(4'd3); load(4'd0);
    total_cnt++;
    if (cur_time() !== 16'h1230) $display("FAIL entry_1230 got %h want 1230", cur_time());
    else pass_cnt++;
    total_cnt++;
    if (timer_done !== 1'b0) $display("FAIL entry_done got %b want 0", timer_done);
    else pass_cnt++;
    load(4'd7);
    total_cnt++;
    if (cur_time() !== 16'h2307) $display("FAIL entry_shift got %h want 2307", cur_time());
    else pass_cnt++;
    load(4'd12);
    total_cnt++;
    if (cur_time() !== 16'h2307) $display("FAIL entry_bad_digit got %h want 2307", cur_time());
    else pass_cnt++;
  endtask

  task automatic test_countdown();
    int ticks;
    load4(16'h0002);
    total_cnt++;
    if (cur_time() !== 16'h0002) $display("FAIL cd_load got %h want 0002", cur_time());
    else pass_cnt++;
    mag_on = 1'b1;
    ticks  = 0;
    for (int k = 1; k <= 16; k++) begin
      step(1);
      if (sec_tick === 1'b1) ticks++;
      if (k == 3) begin
        total_cnt++;
        if (sec_tick !== 1'b0 || cur_time() !== 16'h0002)
          $display("FAIL cd_k3 got tick=%b time=%h want tick=0 time=0002", sec_tick, cur_time());
        else pass_cnt++;
      end
      if (k == 4) begin
        total_cnt++;
        if (sec_tick !== 1'b1 || cur_time() !== 16'h0001)
          $display("FAIL cd_k4 got tick=%b time=%h want tick=1 time=0001", sec_tick, cur_time());
        else pass_cnt++;
      end
      if (k == 7) begin
        total_cnt++;
        if (timer_done !== 1'b0) $display("FAIL cd_k7_done got %b want 0", timer_done);
        else pass_cnt++;
      end
      if (k == 8) begin
        total_cnt++;
        if (sec_tick !== 1'b1 || cur_time() !== 16'h0000 || timer_done !== 1'b1)
          $display("FAIL cd_k8 got tick=%b time=%h done=%b want 1 0000 1", sec_tick, cur_time(), timer_done);
        else pass_cnt++;
      end
    end
    total_cnt++;
    if (ticks !== 2) $display("FAIL cd_tick_count got %0d want 2", ticks);
    else pass_cnt++;
    total_cnt++;
    if (cur_time() !== 16'h0000) $display("FAIL cd_no_wrap got %h want 0000", cur_time());
    else pass_cnt++;
    mag_on = 1'b0;
  endtask

  task automatic test_borrow();
    int done_cyc;
    int ticks;
    load4(16'h1000);
    mag_on = 1'b1;
    step(4);
    total_cnt++;
    if (cur_time() !== 16'h0959 || sec_tick !== 1'b1)
      $display("FAIL borrow_1000 got time=%h tick=%b want 0959 1", cur_time(), sec_tick);
    else pass_cnt++;
    mag_on = 1'b0;
    load4(16'h0090);
    mag_on   = 1'b1;
    done_cyc = 0;
    ticks    = 0;
    for (int c = 1; c <= 400 && done_cyc == 0; c++) begin
      step(1);
      if (sec_tick === 1'b1) ticks++;
      if (c == 4) begin
        total_cnt++;
        if (cur_time() !== 16'h0089) $display("FAIL borrow_90_89 got %h want 0089", cur_time());
        else pass_cnt++;
      end
      if (c == 120) begin
        total_cnt++;
        if (cur_time() !== 16'h0060) $display("FAIL borrow_60 got %h want 0060", cur_time());
        else pass_cnt++;
      end
      if (c == 124) begin
        total_cnt++;
        if (cur_time() !== 16'h0059) $display("FAIL borrow_59 got %h want 0059", cur_time());
        else pass_cnt++;
      end
      if (timer_done === 1'b1) done_cyc = c;
    end
    total_cnt++;
    if (done_cyc !== 360) $display("FAIL borrow_90s_cycles got %0d want 360", done_cyc);
    else pass_cnt++;
    total_cnt++;
    if (ticks !== 90) $display("FAIL borrow_90s_ticks got %0d want 90", ticks);
    else pass_cnt++;
    mag_on = 1'b0;
  endtask

  task automatic test_pause();
    load4(16'h0005);
    mag_on = 1'b1;
    step(6);
    total_cnt++;
    if (cur_time() !== 16'h0004) $display("FAIL pause_run got %h want 0004", cur_time());
    else pass_cnt++;
    mag_on = 1'b0;
    step(10);
    total_cnt++;
    if (cur_time() !== 16'h0004 || sec_tick !== 1'b0)
      $display("FAIL pause_hold got time=%h tick=%b want 0004 0", cur_time(), sec_tick);
    else pass_cnt++;
    mag_on = 1'b1;
    step(1);
    total_cnt++;
    if (sec_tick !== 1'b0 || cur_time() !== 16'h0004)
      $display("FAIL resume_1 got tick=%b time=%h want 0 0004", sec_tick, cur_time());
    else pass_cnt++;
    step(1);
    total_cnt++;
    if (sec_tick !== 1'b1 || cur_time() !== 16'h0003)
      $display("FAIL resume_2 got tick=%b time=%h want 1 0003", sec_tick, cur_time());
    else pass_cnt++;
    mag_on = 1'b0;
  endtask

  task automatic test_clear_midcount();
    load4(16'h0100);
    mag_on = 1'b1;
    step(3);
    clearn     = 1'b0;
    load_digit = 1'b1;
    digit      = 4'd5;
    step(1);
    clearn     = 1'b1;
    load_digit = 1'b0;
    digit      = 4'd0;
    total_cnt++;
    if (cur_time() !== 16'h0000 || timer_done !== 1'b1 || sec_tick !== 1'b0)
      $display("FAIL clear_mid got time=%h done=%b tick=%b want 0000 1 0", cur_time(), timer_done, sec_tick);
    else pass_cnt++;
    mag_on = 1'b0;
    load4(16'h0100);
    mag_on = 1'b1;
    step(3);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    total_cnt++;
    if (cur_time() !== 16'h0000 || timer_done !== 1'b1 || sec_tick !== 1'b0)
      $display("FAIL rst_mid got time=%h done=%b tick=%b want 0000 1 0", cur_time(), timer_done, sec_tick);
    else pass_cnt++;
    mag_on = 1'b0;
  endtask

  task automatic test_load_while_on();
    load4(16'h0003);
    mag_on     = 1'b1;
    load_digit = 1'b1;
    digit      = 4'd7;
    step(1);
    load_digit = 1'b0;
    digit      = 4'd0;
    total_cnt++;
    if (cur_time() !== 16'h0003) $display("FAIL load_on_ignored got %h want 0003", cur_time());
    else pass_cnt++;
    step(3);
    total_cnt++;
    if (cur_time() !== 16'h0002 || sec_tick !== 1'b1)
      $display("FAIL load_on_count got time=%h tick=%b want 0002 1", cur_time(), sec_tick);
    else pass_cnt++;
    mag_on = 1'b0;
  endtask

  initial begin
    pass_cnt   = 0;
    total_cnt  = 0;
    rst        = 1'b1;
    clearn     = 1'b1;
    load_digit = 1'b0;
    digit      = 4'd0;
    mag_on     = 1'b0;
    test_reset();
    test_entry();
    test_countdown();
    test_borrow();
    test_pause();
    test_clear_midcount();
    test_load_while_on();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
